spi_keys: RTL and testbench

//   Keyboard key-matrix state streamer. Continuously samples NUM_KEYS key inputs
//   and sends them as framed, transmit-only SPI (mode 0, no chip select) to a host MCU.

---
 rtl/spi_keys.sv | 206 ++++++++++++++++++++
 tb/tb_spi_keys.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_keys.sv
// -----------------------------------------------------------------------------
// spi_keys
//   Key-matrix state streamer. Samples NUM_KEYS raw key levels through a
//   two-flop synchroniser and repeatedly sends them to a host MCU as a framed,
//   transmit-only SPI stream (mode 0, MSB first, no chip select):
//     SYNC_BYTE, NB key bytes, CHK (XOR of the key bytes).
//   The key field is {keys[NUM_KEYS-1:0], zero pad}, so the first key bit on
//   the wire is keys[NUM_KEYS-1] and the pad bits close the field.
//
// Ports
//   clk_g_i       in   1         system clock, rising edge
//   rstn_g_i      in   1         asynchronous active-low reset
//   spi_clk_g_o   out  1         SCK, idle low, straight from a flop
//   spi_mosi_g_o  out  1         MOSI, straight from a flop
//   keys_i_g      in   NUM_KEYS  raw key levels (1 = pressed), asynchronous
// -----------------------------------------------------------------------------
module spi_keys #(
    parameter int          NUM_KEYS   = 61,
    parameter int          CLK_DIV    = 4,
    parameter int          GAP_CYCLES = 64,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                clk_g_i,
    input  logic                rstn_g_i,
    output logic                spi_clk_g_o,
    output logic                spi_mosi_g_o,
    input  logic [NUM_KEYS-1:0] keys_i_g
);

    localparam int NB   = (NUM_KEYS + 7) / 8;       // key bytes per frame
    localparam int KW   = 8 * NB;                    // key field width incl. pad
    localparam int FB   = 8 * (NB + 2);              // frame length in bits
    localparam int BC_W = $clog2(FB);
    localparam int HC_W = (CLK_DIV > 1)    ? $clog2(CLK_DIV)    : 1;
    localparam int GC_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_GAP   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // XOR of all key bytes; pad bits are already zero in the field.
    function automatic logic [7:0] key_xor(input logic [KW-1:0] field);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < NB; i++) begin
            acc = acc ^ field[8*i +: 8];
        end
        return acc;
    endfunction

    state_e              state_q, state_d;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [GC_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [HC_W-1:0]     half_cnt_q, half_cnt_d;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
    // Holds the not-yet-sent part of the frame; it doubles as the key
    // snapshot, so key changes after LOAD cannot reach the current frame.
    logic [FB-1:0]       shreg_q, shreg_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;

    logic [KW-1:0]       key_field_s;
    logic [FB-1:0]       frame_s;
    logic                half_wrap_s;
    logic                sck_fall_s;
    logic                last_bit_s;

    // Key field: synchronised keys left-aligned, zero pad in the low bits.
    always_comb begin
        key_field_s                    = {KW{1'b0}};
        key_field_s[KW-1 -: NUM_KEYS]  = sync2_q;
    end

    assign frame_s     = {SYNC_BYTE, key_field_s, key_xor(key_field_s)};
    assign half_wrap_s = (state_q == ST_SHIFT) && (half_cnt_q == HC_W'(CLK_DIV - 1));
    assign sck_fall_s  = half_wrap_s && sck_q;
    assign last_bit_s  = (bit_cnt_q == BC_W'(FB - 1));

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            sync1_q <= {NUM_KEYS{1'b0}};
            sync2_q <= {NUM_KEYS{1'b0}};
        end else begin
            sync1_q <= keys_i_g;
            sync2_q <= sync1_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            state_q <= ST_GAP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_GAP: begin
                if (gap_cnt_q == GC_W'(GAP_CYCLES - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sck_fall_s && last_bit_s) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    // FSM output logic: next values of counters, shift register, SCK and MOSI.
    always_comb begin
        gap_cnt_d  = gap_cnt_q;
        half_cnt_d = half_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        case (state_q)
            ST_GAP: begin
                sck_d      = 1'b0;
                mosi_d     = 1'b0;
                half_cnt_d = {HC_W{1'b0}};
                bit_cnt_d  = {BC_W{1'b0}};
                if (gap_cnt_q == GC_W'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = {GC_W{1'b0}};
                end else begin
                    gap_cnt_d = gap_cnt_q + GC_W'(1);
                end
            end
            ST_LOAD: begin
                // Bit 0 goes out now; the rest waits in the shift register.
                mosi_d     = frame_s[FB-1];
                shreg_d    = {frame_s[FB-2:0], 1'b0};
                bit_cnt_d  = {BC_W{1'b0}};
                half_cnt_d = {HC_W{1'b0}};
                gap_cnt_d  = {GC_W{1'b0}};
                sck_d      = 1'b0;
            end
            ST_SHIFT: begin
                if (half_wrap_s) begin
                    half_cnt_d = {HC_W{1'b0}};
                    sck_d      = ~sck_q;
                end else begin
                    half_cnt_d = half_cnt_q + HC_W'(1);
                end
                // MOSI only moves on the clock that drops SCK.
                if (sck_fall_s) begin
                    if (last_bit_s) begin
                        mosi_d = 1'b0;
                    end else begin
                        mosi_d    = shreg_q[FB-1];
                        shreg_d   = {shreg_q[FB-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end else begin
                    mosi_d = mosi_q;
                end
            end
            default: begin
                sck_d  = 1'b0;
                mosi_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk_g_i or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            gap_cnt_q  <= {GC_W{1'b0}};
            half_cnt_q <= {HC_W{1'b0}};
            bit_cnt_q  <= {BC_W{1'b0}};
            shreg_q    <= {FB{1'b0}};
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            gap_cnt_q  <= gap_cnt_d;
            half_cnt_q <= half_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
        end
    end

    assign spi_clk_g_o  = sck_q;
    assign spi_mosi_g_o = mosi_q;

endmodule

// File: tb/tb_spi_keys.sv
// Bench for spi_keys: a default instance (CLK_DIV=4, GAP_CYCLES=64) and a
// fast instance (CLK_DIV=1, GAP_CYCLES=1) share clock, reset and keys.
// A frame-level model predicts SCK/MOSI on every cycle from the cycle count
// since reset; a decoder rebuilds frames on SCK rises for literal checks.
module tb_spi_keys;

    localparam int FBITS = 80;

    logic        clk;
    logic        rstn;
    logic [60:0] keys;
    logic        sck0, mosi0, sck1, mosi1;

    int checks   = 0;
    int failures = 0;

    spi_keys dut (
        .clk_g_i      (clk),
        .rstn_g_i     (rstn),
        .spi_clk_g_o  (sck0),
        .spi_mosi_g_o (mosi0),
        .keys_i_g     (keys)
    );

    spi_keys #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
        .clk_g_i      (clk),
        .rstn_g_i     (rstn),
        .spi_clk_g_o  (sck1),
        .spi_mosi_g_o (mosi1),
        .keys_i_g     (keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame as the host should see it: A5, {keys, 3 zero pad}, XOR of key bytes.
    function automatic logic [79:0] build_frame(input logic [60:0] k);
        logic [63:0] kf;
        logic [7:0]  x;
        kf = {k, 3'b000};
        x  = 8'h00;
        for (int b = 0; b < 8; b++) x = x ^ kf[8*b +: 8];
        return {8'hA5, kf, x};
    endfunction

    // Clock edges seen with reset released.
    int c;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) c <= 0;
        else       c <= c + 1;
    end

    // ---------------- per-cycle model compare ----------------
    logic [60:0] pend [2];
    logic [79:0] cur  [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int d, g, p, x, y, q;
            logic es, em, as, am;
            d  = (i == 0) ? 4 : 1;
            g  = (i == 0) ? 64 : 1;
            p  = 1 + 2 * d * FBITS + g;
            as = (i == 0) ? sck0 : sck1;
            am = (i == 0) ? mosi0 : mosi1;
            es = 1'b0;
            em = 1'b0;
            if (!rstn) begin
                pend[i] = 61'd0;
            end else begin
                // Keys seen here are what the synchroniser hands to the next LOAD.
                x = c - g + 2;
                if (x >= 0 && (x % p) == 0) pend[i] = keys;
                y = c - g - 1;
                q = (y >= 0) ? (y % p) : -1;
                if (q == 0) cur[i] = build_frame(pend[i]);
                if (q >= 0 && q < 2 * d * FBITS) begin
                    es = ((q % (2 * d)) >= d);
                    em = cur[i][FBITS - 1 - q / (2 * d)];
                end
            end
            checks++;
            if (as !== es || am !== em) begin
                failures++;
                if (failures < 20)
                    $display("FAIL cycle_model dut%0d c=%0d: sck/mosi got %b%b exp %b%b",
                             i, c, as, am, es, em);
            end
        end
    end

    // ---------------- frame decoder (samples MOSI on SCK rise) ----------------
    logic [79:0] sh [2];
    logic [79:0] last_frame [2];
    int  bitcnt [2];
    int  frame_cnt [2];
    int  last_start [2];
    int  period [2];
    int  first_start [2];
    bit  have_start [2];
    bit  got_first [2];
    bit  prev [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            frame_cnt[i] = 0; period[i] = 0; first_start[i] = -1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic s, m;
            s = (i == 0) ? sck0 : sck1;
            m = (i == 0) ? mosi0 : mosi1;
            if (!rstn) begin
                bitcnt[i] = 0; prev[i] = 1'b0; got_first[i] = 1'b0; have_start[i] = 1'b0;
            end else begin
                if (s && !prev[i]) begin
                    sh[i] = {sh[i][78:0], m};
                    bitcnt[i]++;
                    if (bitcnt[i] == 1) begin
                        if (have_start[i]) period[i] = c - last_start[i];
                        last_start[i] = c;
                        have_start[i] = 1'b1;
                        if (!got_first[i]) begin
                            first_start[i] = c;
                            got_first[i]   = 1'b1;
                        end
                    end
                    if (bitcnt[i] == FBITS) begin
                        last_frame[i] = sh[i];
                        frame_cnt[i]++;
                        bitcnt[i] = 0;
                    end
                end
                prev[i] = s;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk80(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h exp %h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d exp %0d", name, got, exp);
        end
    endtask

    // Header byte must be A5 and all key bytes XOR the checksum to zero.
    task automatic chk_crc(input string name, input logic [79:0] f);
        logic [7:0] x;
        x = 8'h00;
        for (int b = 0; b < 9; b++) x = x ^ f[8*b +: 8];
        checks++;
        if (x !== 8'h00 || f[79:72] !== 8'hA5) begin
            failures++;
            $display("FAIL %s: header %h residue %h exp A5/00", name, f[79:72], x);
        end
    endtask

    task automatic wait_frames(input int i, input int n);
        int budget;
        budget = 2000 * (n - frame_cnt[i] + 1);
        while (frame_cnt[i] < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (frame_cnt[i] < n) begin
            failures++;
            $display("FAIL wait_frames dut%0d: got %0d frames exp %0d", i, frame_cnt[i], n);
        end
    endtask

    task automatic set_keys(input logic [60:0] k);
        @(posedge clk);
        #1 keys = k;
    endtask

    task automatic frame_with(input string name, input logic [60:0] k, input logic [79:0] exp);
        int n;
        n = frame_cnt[0];
        set_keys(k);
        wait_frames(0, n + 1);
        chk80(name, last_frame[0], exp);
        chk_crc({name, "_chk"}, last_frame[0]);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [60:0] ka, kb;
        int n, budget;
        rstn = 1'b0;
        keys = 61'd0;

        // Model pins from hand-computed frames.
        chk80("model_zero", build_frame(61'd0), 80'hA5_0000000000000000_00);
        chk80("model_ones", build_frame(61'h1FFF_FFFF_FFFF_FFFF), 80'hA5_FFFFFFFFFFFFFFF8_07);
        chk80("model_one",  build_frame(61'h1), 80'hA5_0000000000000008_08);

        repeat (3) @(negedge clk);
        checks++;
        if (sck0 !== 1'b0 || mosi0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: sck/mosi got %b%b exp 00", sck0, mosi0);
        end
        #2 rstn = 1'b1;

        // All-zero keys, two frames, frame period on both instances.
        wait_frames(0, 2);
        chk80("frame_zero", last_frame[0], 80'hA5_0000000000000000_00);
        chk_int("period_default", period[0], 705);
        chk80("fast_frame_zero", last_frame[1], 80'hA5_0000000000000000_00);
        chk_int("period_fast", period[1], 162);

        frame_with("frame_ones", 61'h1FFF_FFFF_FFFF_FFFF, 80'hA5_FFFFFFFFFFFFFFF8_07);
        frame_with("frame_one",  61'h1, 80'hA5_0000000000000008_08);
        frame_with("frame_top",  61'h1000_0000_0000_0000, 80'hA5_8000000000000000_80);

        // Keys change mid-frame: frame keeps its snapshot, next frame updates.
        for (int r = 0; r < 2; r++) begin
            ka = {$urandom, $urandom};
            kb = {$urandom, $urandom};
            n  = frame_cnt[0];
            set_keys(ka);
            repeat (300) @(posedge clk);
            #1 keys = kb;
            wait_frames(0, n + 1);
            chk80("midframe_old", last_frame[0], build_frame(ka));
            chk_crc("midframe_old_chk", last_frame[0]);
            wait_frames(0, n + 2);
            chk80("midframe_new", last_frame[0], build_frame(kb));
            chk_crc("midframe_new_chk", last_frame[0]);
        end

        // Reset while SCK is high mid-frame.
        budget = 2000;
        while (sck0 !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk_int("sck_seen_high", int'(sck0), 1);
        @(negedge clk);
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (sck0 !== 1'b0 || mosi0 !== 1'b0 || sck1 !== 1'b0 || mosi1 !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: outputs got %b%b%b%b exp 0000", sck0, mosi0, sck1, mosi1);
        end
        #100;
        @(negedge clk);
        #2 rstn = 1'b1;
        n = frame_cnt[0];
        wait_frames(0, n + 1);
        chk80("post_reset_frame", last_frame[0], build_frame(kb));
        chk_int("first_rise_default", first_start[0], 69);
        chk_int("first_rise_fast", first_start[1], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
